// File: rtl/q15_divider.sv
// Sequential signed Q15 divider (sign + 15 integer bits, 48 fractional bits).
// Restoring division, one quotient bit per clock, start/done handshake.
// Overflow saturates to the signed extremes; a zero divisor raises nan.
module q15_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] res,
    output logic        nan
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DIV   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [63:0] a_reg;
    logic [63:0] b_reg;
    logic        sign_reg;
    logic [63:0] rem_reg;       // partial remainder, always below |b|
    logic [63:0] dvd_reg;       // remaining dividend bits, MSB shifted out first
    logic [63:0] q_reg;         // quotient being built, or the precomputed special result
    logic [5:0]  count_reg;
    logic        bypass_reg;    // special case: q_reg already holds the final result
    logic        nan_pend_reg;
    logic [63:0] res_reg;
    logic        nan_reg;

    // Magnitudes; negating 0x8000_0000_0000_0000 yields itself, read as 2^63.
    logic [63:0] abs_a;
    logic [63:0] abs_b;
    logic        ovf;
    logic [64:0] rem_shift;
    logic        ge;
    logic [63:0] q_new;

    assign abs_a     = a_reg[63] ? (~a_reg + 64'd1) : a_reg;
    assign abs_b     = b_reg[63] ? (~b_reg + 64'd1) : b_reg;
    // Quotient would reach 2^63 when |a| >= |b| * 2^15 (79-bit compare).
    assign ovf       = {15'd0, abs_a} >= {abs_b, 15'd0};
    assign rem_shift = {rem_reg, dvd_reg[63]};
    assign ge        = rem_shift >= {1'b0, abs_b};
    assign q_new     = {q_reg[62:0], ge};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                state_next = DIV;
            end
            DIV: begin
                if (bypass_reg || (count_reg == 6'd0)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, precheck, restoring iterations, result register.
    // Special cases spend one cycle in DIV with the answer preloaded so every
    // result is registered on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg        <= '0;
            b_reg        <= '0;
            sign_reg     <= 1'b0;
            rem_reg      <= '0;
            dvd_reg      <= '0;
            q_reg        <= '0;
            count_reg    <= '0;
            bypass_reg   <= 1'b0;
            nan_pend_reg <= 1'b0;
            res_reg      <= '0;
            nan_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        sign_reg <= a[63] ^ b[63];
                    end
                end
                CHECK: begin
                    count_reg <= '0;
                    rem_reg   <= '0;
                    dvd_reg   <= '0;
                    if (b_reg == 64'd0) begin
                        bypass_reg   <= 1'b1;
                        nan_pend_reg <= 1'b1;
                        q_reg        <= '0;
                    end else if (ovf) begin
                        bypass_reg   <= 1'b1;
                        nan_pend_reg <= 1'b0;
                        q_reg        <= sign_reg ? 64'h8000_0000_0000_0000
                                                 : 64'h7fff_ffff_ffff_ffff;
                    end else if (a_reg == 64'd0) begin
                        bypass_reg   <= 1'b1;
                        nan_pend_reg <= 1'b0;
                        q_reg        <= '0;
                    end else begin
                        // Dividend is |a|<<48 (112 bits). The top 48 bits can
                        // never produce a quotient bit (q < 2^63), so they are
                        // preloaded straight into the remainder.
                        bypass_reg   <= 1'b0;
                        nan_pend_reg <= 1'b0;
                        rem_reg      <= {16'd0, abs_a[63:16]};
                        dvd_reg      <= {abs_a[15:0], 48'd0};
                        q_reg        <= '0;
                        count_reg    <= 6'd63;
                    end
                end
                DIV: begin
                    if (bypass_reg) begin
                        res_reg <= q_reg;
                        nan_reg <= nan_pend_reg;
                    end else begin
                        rem_reg <= ge ? 64'(rem_shift - {1'b0, abs_b}) : rem_shift[63:0];
                        dvd_reg <= {dvd_reg[62:0], 1'b0};
                        q_reg   <= q_new;
                        if (count_reg == 6'd0) begin
                            res_reg <= sign_reg ? (~q_new + 64'd1) : q_new;
                            nan_reg <= 1'b0;
                        end else begin
                            count_reg <= count_reg - 6'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign res = res_reg;
    assign nan = nan_reg;

endmodule

// File: tb/tb_q15_divider.sv
// Self-checking bench for q15_divider: directed cases, random operands
// against an arithmetic reference model, ignored start, and mid-run reset.
module tb_q15_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] res;
    logic        nan;

    int checks;
    int errors;

    logic [63:0] last_res;
    logic        last_nan;

    q15_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .res   (res),
        .nan   (nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: quotient = a/b scaled by 2^48, truncated toward zero.
    function automatic void model(input logic [63:0] ma, input logic [63:0] mb,
                                  output logic [63:0] r, output logic n, output int lat);
        logic [63:0]  ua;
        logic [63:0]  ub;
        logic [111:0] num;
        logic [111:0] quo;
        logic         neg;
        ua  = ma[63] ? -ma : ma;
        ub  = mb[63] ? -mb : mb;
        neg = ma[63] ^ mb[63];
        n   = 1'b0;
        lat = 2;
        if (mb == 64'd0) begin
            r = 64'd0;
            n = 1'b1;
        end else if ({15'd0, ua} >= {ub, 15'd0}) begin
            r = neg ? 64'h8000_0000_0000_0000 : 64'h7fff_ffff_ffff_ffff;
        end else if (ma == 64'd0) begin
            r = 64'd0;
        end else begin
            num = {ua, 48'd0};
            quo = num / {48'd0, ub};
            r   = neg ? -quo[63:0] : quo[63:0];
            lat = 65;
        end
    endfunction

    // One complete operation with handshake, latency and result checks.
    task automatic run_op(input logic [63:0] ta, input logic [63:0] tbv, input string tag);
        logic [63:0] er;
        logic        en;
        int          el;
        int          lat;
        bit          seen;
        model(ta, tbv, er, en, el);
        @(negedge clk);
        a     = ta;
        b     = tbv;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = '1;
        b     = '1;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 200 && !seen; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_latency"}, 64'(lat), 64'(el));
        chk({tag, "_res"}, res, er);
        chk({tag, "_nan"}, 64'(nan), 64'(en));
        last_res = res;
        last_nan = nan;
        $display("op %s a=%h b=%h res=%h nan=%0d lat=%0d", tag, ta, tbv, res, nan, lat);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int          dones;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] er;
        logic        en;
        int          el;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_res", res, 64'd0);
        chk("reset_nan", 64'(nan), 64'd0);
        rst_n = 1'b1;

        // Directed cases with literal expectations.
        run_op(64'h0009000000000000, 64'h0008000000000000, "nine_eighths");
        chk("nine_eighths_lit", last_res, 64'h0001200000000000);
        run_op(64'hfff7000000000000, 64'h0008000000000000, "neg_nine_eighths");
        chk("neg_nine_eighths_lit", last_res, 64'hfffee00000000000);
        run_op(64'h0001000000000000, 64'h0003000000000000, "one_third");
        chk("one_third_lit", last_res, 64'h0000555555555555);
        run_op(64'h7fff000000000000, 64'h0000800000000000, "sat_pos");
        chk("sat_pos_lit", last_res, 64'h7fffffffffffffff);
        run_op(64'h7fff000000000000, 64'hffff800000000000, "sat_neg");
        chk("sat_neg_lit", last_res, 64'h8000000000000000);
        run_op(64'h0001000000000000, 64'h0000000000000000, "div_zero");
        chk("div_zero_nan_lit", 64'(last_nan), 64'd1);
        run_op(64'h0000000000000000, 64'h0000000000000000, "zero_zero");
        chk("zero_zero_nan_lit", 64'(last_nan), 64'd1);
        run_op(64'h0000000000000000, 64'hfffd000000000000, "zero_dividend");
        run_op(64'h8000000000000000, 64'h7fffffffffffffff, "min_dividend");

        // Random operands, scaled so that most divisions are in range.
        for (int i = 0; i < 16; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            ra = 64'($signed(ra) >>> $urandom_range(0, 30));
            rb = 64'($signed(rb) >>> $urandom_range(10, 40));
            run_op(ra, rb, $sformatf("rand%0d", i));
        end

        // Start pulsed mid-DIV with new operands must be ignored.
        model(64'h0009000000000000, 64'h0008000000000000, er, en, el);
        @(negedge clk);
        a     = 64'h0009000000000000;
        b     = 64'h0008000000000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        a     = 64'h0001000000000000;
        b     = 64'h0003000000000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                chk("ignored_start_res", res, er);
                @(negedge clk);
                chk("ignored_start_busy_fall", 64'(busy), 64'd0);
            end
        end
        chk("ignored_start_done_count", 64'(dones), 64'd1);
        $display("op ignored_start res=%h dones=%0d", res, dones);

        // Reset in the middle of DIV aborts and clears outputs.
        @(negedge clk);
        a     = 64'h0009000000000000;
        b     = 64'h0008000000000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        chk("midreset_res", res, 64'd0);
        chk("midreset_nan", 64'(nan), 64'd0);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("midreset_no_done", 64'(dones), 64'd0);
        $display("op mid_reset res=%h dones=%0d", res, dones);
        run_op(64'h0009000000000000, 64'h0008000000000000, "after_reset");
        chk("after_reset_lit", last_res, 64'h0001200000000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
